// File: rtl/noc_va_pkg.sv
// Shared types and helpers for the output-port VC allocator.
package noc_va_pkg;

    localparam int VCID_W = 2;

    typedef enum logic [1:0] {
        VC_FREE    = 2'd0,
        VC_CLAIMED = 2'd1,
        VC_OWNED   = 2'd2
    } vc_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/va_rr_arbiter.sv
// Round-robin arbiter: first unmasked request at or above the pointer, wrapping.
// The pointer moves past the winner only when the caller commits the grant.
module va_rr_arbiter
    import noc_va_pkg::*;
#(
    parameter int  NUM_REQ = 8,
    localparam int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic               advance_i,
    output logic               valid_o,
    output logic [NUM_REQ-1:0] gnt_onehot_o,
    output logic [REQ_W-1:0]   gnt_idx_o
);

    logic [REQ_W-1:0]   ptr_q;
    logic [REQ_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] elig;
    logic [REQ_W:0]     scan_sum;
    logic [REQ_W-1:0]   scan_idx;

    assign elig = req_i & ~mask_i;

    // Scan from the farthest offset down so the one nearest the pointer wins.
    always_comb begin
        valid_o   = 1'b0;
        gnt_idx_o = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, ptr_q} + (REQ_W+1)'(k);
            if (scan_sum >= (REQ_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (REQ_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[REQ_W-1:0];
            if (elig[scan_idx]) begin
                valid_o   = 1'b1;
                gnt_idx_o = scan_idx;
            end
        end
    end

    assign gnt_onehot_o = valid_o ? (NUM_REQ'(1) << gnt_idx_o) : '0;

    assign ptr_d = advance_i ? REQ_W'(rr_next(int'(gnt_idx_o), NUM_REQ)) : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/output_vc_allocator.sv
// Output VC allocator: round-robin requester pick, lowest eligible VC, per-VC claim tracking.
// Build option VA_READY_GATE_EN: a VC must also show vc_ready to be eligible.
//   state   | meaning
//   FREE    | unclaimed; grantable while vc_avail is high
//   CLAIMED | granted; waiting for the controller to drop vc_avail
//   OWNED   | in use until the controller raises vc_avail again
module output_vc_allocator
    import noc_va_pkg::*;
#(
    parameter int  NUM_REQ = 8,
    parameter int  NUM_VC  = 4,
    localparam int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_VC-1:0]       vc_avail,
    input  logic [NUM_VC-1:0]       vc_ready,
    output logic                    gnt_valid,
    output logic [NUM_REQ-1:0]      gnt_req,
    output logic [VCID_W-1:0]       gnt_vcid,
    output logic [NUM_VC-1:0]       avail_reset,
    output logic [NUM_VC*REQ_W-1:0] vc_owner,
    output logic [NUM_VC-1:0]       vc_owned
);

    logic                    arb_valid;
    logic [NUM_REQ-1:0]      arb_onehot;
    logic [REQ_W-1:0]        arb_idx;
    logic [NUM_REQ-1:0]      req_mask;
    logic [NUM_VC-1:0]       vc_free;
    logic [NUM_VC-1:0]       vc_elig;
    logic [NUM_VC-1:0]       claim;
    logic                    vc_found;
    logic [VCID_W-1:0]       vc_sel;
    logic                    alloc;

    logic                    gnt_valid_q,   gnt_valid_d;
    logic [NUM_REQ-1:0]      gnt_req_q,     gnt_req_d;
    logic [VCID_W-1:0]       gnt_vcid_q,    gnt_vcid_d;
    logic [NUM_VC-1:0]       avail_reset_q, avail_reset_d;
    logic [NUM_VC*REQ_W-1:0] vc_owner_q,    vc_owner_d;

    // A requester still sees req high in its grant cycle; keep it out of that round.
    assign req_mask = gnt_valid_q ? gnt_req_q : '0;

    va_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .mask_i       (req_mask),
        .advance_i    (alloc),
        .valid_o      (arb_valid),
        .gnt_onehot_o (arb_onehot),
        .gnt_idx_o    (arb_idx)
    );

`ifdef VA_READY_GATE_EN
    assign vc_elig = vc_free & vc_avail & vc_ready;
`else
    assign vc_elig = vc_free & vc_avail;
    logic unused_vc_ready;
    assign unused_vc_ready = ^vc_ready;
`endif

    always_comb begin
        vc_found = 1'b0;
        vc_sel   = '0;
        for (int v = NUM_VC - 1; v >= 0; v--) begin
            if (vc_elig[v]) begin
                vc_found = 1'b1;
                vc_sel   = VCID_W'(v);
            end
        end
    end

    assign alloc = arb_valid && vc_found;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_state_e state_q;
        vc_state_e state_d;

        assign claim[v] = alloc && (vc_sel == VCID_W'(v));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= VC_FREE;
            end else begin
                state_q <= state_d;
            end
        end

        // CLAIMED holds while vc_avail is still high: the controller lags the reset pulse by a cycle.
        always_comb begin
            state_d = state_q;
            case (state_q)
                VC_FREE:    if (claim[v])     state_d = VC_CLAIMED;
                VC_CLAIMED: if (!vc_avail[v]) state_d = VC_OWNED;
                VC_OWNED:   if (vc_avail[v])  state_d = VC_FREE;
                default:                      state_d = VC_FREE;
            endcase
        end

        assign vc_free[v]  = (state_q == VC_FREE);
        assign vc_owned[v] = (state_q != VC_FREE);
    end

    // Owner slots are only overwritten on a claim, so they keep the last owner after release.
    always_comb begin
        gnt_valid_d   = alloc;
        gnt_req_d     = alloc ? arb_onehot : '0;
        gnt_vcid_d    = alloc ? vc_sel : '0;
        avail_reset_d = claim;
        vc_owner_d    = vc_owner_q;
        for (int v = 0; v < NUM_VC; v++) begin
            if (claim[v]) begin
                vc_owner_d[v*REQ_W +: REQ_W] = arb_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_valid_q   <= 1'b0;
            gnt_req_q     <= '0;
            gnt_vcid_q    <= '0;
            avail_reset_q <= '0;
            vc_owner_q    <= '0;
        end else begin
            gnt_valid_q   <= gnt_valid_d;
            gnt_req_q     <= gnt_req_d;
            gnt_vcid_q    <= gnt_vcid_d;
            avail_reset_q <= avail_reset_d;
            vc_owner_q    <= vc_owner_d;
        end
    end

    assign gnt_valid   = gnt_valid_q;
    assign gnt_req     = gnt_req_q;
    assign gnt_vcid    = gnt_vcid_q;
    assign avail_reset = avail_reset_q;
    assign vc_owner    = vc_owner_q;

endmodule

// File: tb/tb_output_vc_allocator.sv
// Bench for output_vc_allocator: directed scenarios plus random traffic against a
// cycle-level reference model of the allocation rules.
module tb_output_vc_allocator;

    localparam int NR = 8;
    localparam int NV = 4;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req = '0;
    logic [NV-1:0] vc_avail = '1;
    logic [NV-1:0] vc_ready = '1;
    logic          gnt_valid;
    logic [NR-1:0] gnt_req;
    logic [1:0]    gnt_vcid;
    logic [NV-1:0] avail_reset;
    logic [NV*RW-1:0] vc_owner;
    logic [NV-1:0] vc_owned;

    output_vc_allocator #(.NUM_REQ(NR), .NUM_VC(NV)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .vc_avail    (vc_avail),
        .vc_ready    (vc_ready),
        .gnt_valid   (gnt_valid),
        .gnt_req     (gnt_req),
        .gnt_vcid    (gnt_vcid),
        .avail_reset (avail_reset),
        .vc_owner    (vc_owner),
        .vc_owned    (vc_owned)
    );

    always #5 clk = ~clk;

    wire [30:0] dut_bus = {gnt_valid, gnt_req, gnt_vcid, avail_reset, vc_owned, vc_owner};

    int vectors = 0;
    int miscompares = 0;

    // Reference model: state per VC (0 free, 1 claimed, 2 owned), owners, pointer, last grant.
    int  m_state [NV];
    int  m_owner [NV];
    int  m_ptr;
    bit  m_gv;
    int  m_gr;
    int  m_gvc;
    logic [30:0] e_bus;

    function automatic void derive_expected();
        logic [NR-1:0]    greq;
        logic [NV-1:0]    ar;
        logic [1:0]       vcid;
        logic [NV-1:0]    owned;
        logic [NV*RW-1:0] owner;
        greq = m_gv ? (NR'(1) << m_gr) : '0;
        ar   = m_gv ? (NV'(1) << m_gvc) : '0;
        vcid = m_gv ? 2'(m_gvc) : 2'd0;
        owner = '0;
        owned = '0;
        for (int v = 0; v < NV; v++) begin
            owned[v] = (m_state[v] != 0);
            owner[v*RW +: RW] = RW'(m_owner[v]);
        end
        e_bus = {m_gv, greq, vcid, ar, owned, owner};
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_state[v] = 0;
            m_owner[v] = 0;
        end
        m_ptr = 0;
        m_gv  = 1'b0;
        m_gr  = 0;
        m_gvc = 0;
        derive_expected();
    endfunction

    // Decide from the current inputs, cross one clock edge, then advance the model.
    task automatic tick();
        int cv;
        int w;
        int idx;
        int ns [NV];
        bit rdy;
        cv = -1;
        w  = -1;
        for (int v = 0; v < NV; v++) begin
`ifdef VA_READY_GATE_EN
            rdy = vc_ready[v];
`else
            rdy = 1'b1;
`endif
            if (cv < 0 && m_state[v] == 0 && vc_avail[v] && rdy) cv = v;
        end
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (w < 0 && req[idx] && !(m_gv && m_gr == idx)) w = idx;
        end
        for (int v = 0; v < NV; v++) begin
            ns[v] = m_state[v];
            if (m_state[v] == 1 && !vc_avail[v]) ns[v] = 2;
            else if (m_state[v] == 2 && vc_avail[v]) ns[v] = 0;
        end
        @(posedge clk);
        #1;
        for (int v = 0; v < NV; v++) m_state[v] = ns[v];
        if (cv >= 0 && w >= 0) begin
            m_state[cv] = 1;
            m_owner[cv] = w;
            m_ptr = (w + 1) % NR;
            m_gv  = 1'b1;
            m_gr  = w;
            m_gvc = cv;
        end else begin
            m_gv = 1'b0;
        end
        derive_expected();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        vc_avail = '1;
        vc_ready = '1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (dut_bus !== 31'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", dut_bus, 31'd0);
        end
        tick();
        vectors++;
        if (dut_bus !== e_bus) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", dut_bus, e_bus);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req = 8'h04;
        tick();
        vectors++;
        if ({gnt_valid, gnt_req, gnt_vcid, avail_reset, vc_owner[2:0], vc_owned} !==
            {1'b1, 8'h04, 2'd0, 4'b0001, 3'd2, 4'b0001}) begin
            miscompares++;
            $display("FAIL single_grant: got v=%b r=%h vc=%0d ar=%b own0=%0d owned=%b expected v=1 r=04 vc=0 ar=0001 own0=2 owned=0001",
                     gnt_valid, gnt_req, gnt_vcid, avail_reset, vc_owner[2:0], vc_owned);
        end
        // Pointer now 3: of requesters 0 and 3, requester 3 must win.
        req = 8'h09;
        tick();
        vectors++;
        if ({gnt_req, gnt_vcid} !== {8'h08, 2'd1} || dut_bus !== e_bus) begin
            miscompares++;
            $display("FAIL single_pointer: got r=%h vc=%0d bus=%h expected r=08 vc=1 bus=%h", gnt_req, gnt_vcid, dut_bus, e_bus);
        end
        req = 8'h01;
        tick();
        vectors++;
        if (dut_bus !== e_bus) begin
            miscompares++;
            $display("FAIL single_next: got %h expected %h", dut_bus, e_bus);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req = 8'hFF;
        for (int k = 0; k < NV; k++) begin
            tick();
            vectors++;
            if ({gnt_valid, gnt_req, gnt_vcid, avail_reset} !== {1'b1, NR'(1) << k, 2'(k), NV'(1) << k} ||
                dut_bus !== e_bus) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got r=%h vc=%0d ar=%b expected r=%h vc=%0d", k, gnt_req, gnt_vcid,
                         avail_reset, NR'(1) << k, k);
            end
            if (k > 0) req[k-1] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (gnt_valid !== 1'b0 || dut_bus !== e_bus) begin
                miscompares++;
                $display("FAIL rr_all_busy: got v=%b bus=%h expected v=0 bus=%h", gnt_valid, dut_bus, e_bus);
            end
            req[3] = 1'b0;
        end
    endtask

    task automatic test_lag_release();
        apply_reset();
        req = 8'h01;
        tick();
        req = 8'h02;
        tick();
        vectors++;
        if ({gnt_req, gnt_vcid} !== {8'h02, 2'd1} || dut_bus !== e_bus) begin
            miscompares++;
            $display("FAIL lag_no_regrant: got r=%h vc=%0d expected r=02 vc=1", gnt_req, gnt_vcid);
        end
        req = 8'h00;
        tick();
        vectors++;
        if ({gnt_valid, vc_owned} !== {1'b0, 4'b0011}) begin
            miscompares++;
            $display("FAIL lag_claimed: got v=%b owned=%b expected v=0 owned=0011", gnt_valid, vc_owned);
        end
        vc_avail = 4'b1100;
        tick();
        req = 8'h04;
        vc_avail = 4'b0001;
        tick();
        vectors++;
        if ({gnt_valid, vc_owned, vc_owner[2:0]} !== {1'b0, 4'b0010, 3'd0} || dut_bus !== e_bus) begin
            miscompares++;
            $display("FAIL release_edge: got v=%b owned=%b own0=%0d expected v=0 owned=0010 own0=0", gnt_valid, vc_owned, vc_owner[2:0]);
        end
        tick();
        vectors++;
        if ({gnt_req, gnt_vcid, vc_owner[2:0], vc_owned} !== {8'h04, 2'd0, 3'd2, 4'b0011} || dut_bus !== e_bus) begin
            miscompares++;
            $display("FAIL release_regrant: got r=%h vc=%0d own0=%0d owned=%b expected r=04 vc=0 own0=2 owned=0011",
                     gnt_req, gnt_vcid, vc_owner[2:0], vc_owned);
        end
    endtask

    task automatic test_wrap_mask();
        apply_reset();
        req = 8'h40;
        tick();
        req = 8'h81;
        tick();
        vectors++;
        if ({gnt_req, gnt_vcid} !== {8'h80, 2'd1} || dut_bus !== e_bus) begin
            miscompares++;
            $display("FAIL wrap_grant7: got r=%h vc=%0d expected r=80 vc=1", gnt_req, gnt_vcid);
        end
        tick();
        vectors++;
        if ({gnt_req, gnt_vcid} !== {8'h01, 2'd2} || dut_bus !== e_bus) begin
            miscompares++;
            $display("FAIL wrap_mask: got r=%h vc=%0d expected r=01 vc=2", gnt_req, gnt_vcid);
        end
        req = 8'h00;
        tick();
        vectors++;
        if (gnt_valid !== 1'b0 || dut_bus !== e_bus) begin
            miscompares++;
            $display("FAIL wrap_idle: got %h expected %h", dut_bus, e_bus);
        end
    endtask

    task automatic test_gate();
        logic [1:0] want;
`ifdef VA_READY_GATE_EN
        want = 2'd1;
`else
        want = 2'd0;
`endif
        apply_reset();
        vc_ready = 4'b1110;
        req = 8'h01;
        tick();
        vectors++;
        if ({gnt_valid, gnt_vcid} !== {1'b1, want} || dut_bus !== e_bus) begin
            miscompares++;
            $display("FAIL gate_vcid: got v=%b vc=%0d expected v=1 vc=%0d", gnt_valid, gnt_vcid, want);
        end
        vc_ready = '1;
        req = 8'h00;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 8'hFF;
        tick();
        tick();
        #2;
        rst = 1'b1;
        vc_avail = '1;
        #1;
        model_reset();
        vectors++;
        if (dut_bus !== 31'd0) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %h expected %h", dut_bus, 31'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 8'h01;
        vc_avail = 4'b1000;
        tick();
        vectors++;
        if ({gnt_req, gnt_vcid, vc_owned} !== {8'h01, 2'd3, 4'b1000} || dut_bus !== e_bus) begin
            miscompares++;
            $display("FAIL reset_mid_free: got r=%h vc=%0d owned=%b expected r=01 vc=3 owned=1000", gnt_req, gnt_vcid, vc_owned);
        end
        req = 8'h00;
    endtask

    task automatic test_random();
        logic [NR-1:0] drop;
        apply_reset();
        drop = '0;
        for (int n = 0; n < 500; n++) begin
            req = (req & ~drop) | (NR'($urandom & $urandom) & ~drop);
            drop = e_bus[29:22];
            vc_avail = NV'($urandom | $urandom);
            vc_ready = NV'($urandom | $urandom);
            tick();
            vectors++;
            if (dut_bus !== e_bus) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, dut_bus, e_bus);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_lag_release();
        test_wrap_mask();
        test_gate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
